// File: rtl/ram512_streamer_pkg.sv
// ---------------------------------------------------------------------------
// ram512_streamer_pkg
//   Shared definitions for the RAM512 streamer: word/address/length widths,
//   FSM state encoding, transfer mode encoding and the transfer-length clamp.
//   No ports; imported by the interface, the top level and the sub-module.
// ---------------------------------------------------------------------------
package ram512_streamer_pkg;

    localparam int DATA_W    = 16;   // matches RAM512 data width
    localparam int ADDR_W    = 9;    // 512-word RAM
    localparam int CNT_W     = 10;   // holds 0..512
    localparam int MAX_WORDS = 512;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        MODE_WRITE = 1'b0,
        MODE_READ  = 1'b1
    } mode_t;

    // Lengths beyond the RAM size are limited to one full pass over the RAM.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
        if (c > CNT_W'(MAX_WORDS))
            return CNT_W'(MAX_WORDS);
        return c;
    endfunction

endpackage

// File: rtl/ram512_streamer_if.sv
// ---------------------------------------------------------------------------
// ram512_streamer_if
//   Bundles every non-clock signal of the streamer:
//     control   : start, mode, base, count (in)  / busy, done (out)
//     write in  : s_data, s_valid (in) / s_ready (out)
//     read out  : m_data, m_valid (out) / m_ready (in)
//     RAM port  : mem_in, mem_load, mem_address (out) / mem_out (in)
//   modport master : the streamer itself (initiator of the RAM port)
//   modport slave  : the environment (loader/debug link plus the RAM)
// ---------------------------------------------------------------------------
interface ram512_streamer_if;
    import ram512_streamer_pkg::*;

    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  count;

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    logic [DATA_W-1:0] mem_in;
    logic              mem_load;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_out;

    logic              busy;
    logic              done;

    modport master (
        input  start, mode, base, count,
        input  s_data, s_valid, m_ready, mem_out,
        output s_ready, m_data, m_valid,
        output mem_in, mem_load, mem_address,
        output busy, done
    );

    modport slave (
        output start, mode, base, count,
        output s_data, s_valid, m_ready, mem_out,
        input  s_ready, m_data, m_valid,
        input  mem_in, mem_load, mem_address,
        input  busy, done
    );

endinterface

// File: rtl/ram512_streamer_addr_counter.sv
// ---------------------------------------------------------------------------
// ram512_streamer_addr_counter
//   Holds the current RAM address (wraps 511 -> 0) and the number of words
//   still to transfer.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     load       : capture load_addr / load_cnt (has priority over step)
//     step       : one word transferred; advance address, decrement count
//     load_addr  : first address of the transfer
//     load_cnt   : clamped transfer length
//     addr       : current address
//     last       : exactly one word left
// ---------------------------------------------------------------------------
module ram512_streamer_addr_counter
    import ram512_streamer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [CNT_W-1:0]  load_cnt,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= load_addr;
            remaining <= load_cnt;
        end else if (step) begin
            // natural 9-bit overflow gives the 511 -> 0 wrap
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    assign last = (remaining == CNT_W'(1));

endmodule

// File: rtl/ram512_streamer.sv
// ---------------------------------------------------------------------------
// ram512_streamer
//   Initiator side of a RAM512 port. WRITE mode stores a valid/ready word
//   stream at consecutive addresses; READ mode walks consecutive addresses
//   and presents each word as a valid/ready stream.
//   Ports:
//     clk  : system clock
//     rst  : asynchronous active-high reset
//     bus  : ram512_streamer_if.master (control, both streams, RAM port)
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | waiting for start; mode/base/count sampled here
//   S_WRITE | accepting s_data, one RAM write per handshake
//   S_READ  | presenting RAM words on m_data
//   S_DONE  | one-cycle done pulse, then back to S_IDLE
// ---------------------------------------------------------------------------
module ram512_streamer
    import ram512_streamer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    ram512_streamer_if.master   bus
);

    state_t            state;
    logic              s_ready_q;
    logic              m_valid_q;
    logic              busy_q;
    logic              done_q;

    logic              load;
    logic              w_hs;
    logic              r_hs;
    logic              step;
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  start_cnt;

    assign start_cnt = clamp_count(bus.count);
    assign load      = (state == S_IDLE) && bus.start;
    // s_ready_q / m_valid_q are only ever set in their own state, so they
    // double as state qualifiers for the handshakes.
    assign w_hs      = s_ready_q && bus.s_valid;
    assign r_hs      = m_valid_q && bus.m_ready;
    assign step      = w_hs || r_hs;

    ram512_streamer_addr_counter u_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .load_addr (bus.base),
        .load_cnt  (start_cnt),
        .addr      (addr),
        .last      (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (start_cnt == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else if (bus.mode == MODE_READ) begin
                            state     <= S_READ;
                            m_valid_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end else begin
                            state     <= S_WRITE;
                            s_ready_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_hs && last) begin
                        state     <= S_DONE;
                        s_ready_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                S_READ: begin
                    if (r_hs && last) begin
                        state     <= S_DONE;
                        m_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    s_ready_q <= 1'b0;
                    m_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.m_valid     = m_valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    // Zero-latency write: the word commits on the same edge as the handshake.
    // Built from a reset-cleared flop so an async reset drops it immediately.
    assign bus.mem_load    = w_hs;
    assign bus.mem_in      = bus.s_data;
    assign bus.mem_address = addr;
    assign bus.m_data      = bus.mem_out;

endmodule

// File: tb/tb_ram512_streamer.sv
// ---------------------------------------------------------------------------
// tb_ram512_streamer
//   Pairs the streamer with a behavioural RAM512 and checks transfers against
//   an independent word-array model of the RAM contents.
// ---------------------------------------------------------------------------
module tb_ram512_streamer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram512_streamer_if bus();

    ram512_streamer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // behavioural RAM512: combinational read, write on rising edge while load
    logic [15:0] ram [512];
    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 16'(i * 37 + 5);
        forever begin
            @(posedge clk);
            if (bus.mem_load) ram[bus.mem_address] <= bus.mem_in;
        end
    end
    assign bus.mem_out = ram[bus.mem_address];

    logic [15:0] exp_ram [512];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic start_xfer(input logic md, input int b, input int cnt);
        bus.start = 1'b1;
        bus.mode  = md;
        bus.base  = 9'(b);
        bus.count = 10'(cnt);
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.s_ready, bus.m_valid, bus.mem_load, bus.done} !== 5'b0) begin
            n_bad++;
            $display("FAIL start_idle: busy/s_ready/m_valid/mem_load/done got %b want 00000",
                     {bus.busy, bus.s_ready, bus.m_valid, bus.mem_load, bus.done});
        end
        @(posedge clk); #1;
        // scramble the command inputs: they must not be resampled mid-transfer
        bus.start = 1'b0;
        bus.mode  = 1'($urandom);
        bus.base  = 9'($urandom);
        bus.count = 10'($urandom);
    endtask

    task automatic finish_xfer(input string tag);
        n_cmp++;
        if ({bus.done, bus.busy, bus.s_ready, bus.m_valid, bus.mem_load} !== 5'b10000) begin
            n_bad++;
            $display("FAIL %s done_pulse: done/busy/s_ready/m_valid/mem_load got %b want 10000",
                     tag, {bus.done, bus.busy, bus.s_ready, bus.m_valid, bus.mem_load});
        end
        bus.start = 1'b1;   // ignored in DONE
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL %s back_to_idle: done/busy got %b want 00", tag, {bus.done, bus.busy});
        end
    endtask

    // gap_mode: 0 = s_valid always high, 1 = random gaps, 2 = repeating 1,0,0,1
    task automatic run_write(input int b, input int cnt, input int gap_mode,
                             input logic [15:0] words[$], input string tag);
        int n, a, hs, cyc;
        logic v;
        logic [15:0] w;
        n   = (cnt > 512) ? 512 : cnt;
        a   = b;
        hs  = 0;
        cyc = 0;
        start_xfer(1'b0, b, cnt);
        while (hs < n && cyc < 4 * n + 20) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 2) != 0);
                default: v = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            endcase
            w = (hs < words.size()) ? words[hs] : 16'($urandom);
            bus.s_valid = v;
            bus.s_data  = w;
            @(negedge clk);
            n_cmp++;
            if ({bus.s_ready, bus.m_valid, bus.busy, bus.mem_load, bus.mem_address, bus.mem_in}
                !== {1'b1, 1'b0, 1'b1, v, 9'(a), w}) begin
                n_bad++;
                $display("FAIL %s write_cycle %0d: rdy/mv/busy/load=%b%b%b%b addr=%0d in=%h want 1 0 1 %b addr=%0d in=%h",
                         tag, cyc, bus.s_ready, bus.m_valid, bus.busy, bus.mem_load,
                         bus.mem_address, bus.mem_in, v, a, w);
            end
            if (v) begin
                exp_ram[a] = w;
                a = (a + 1) % 512;
                hs++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.s_valid = 1'b0;
        n_cmp++;
        if (hs != n) begin
            n_bad++;
            $display("FAIL %s write_timeout: handshakes got %0d want %0d", tag, hs, n);
        end
        finish_xfer(tag);
    endtask

    // stall_mode: 0 = m_ready always high, 1 = random, 2 = 2-cycle stall on 2nd word
    task automatic run_read(input int b, input int cnt, input int stall_mode, input string tag);
        int n, a, hs, cyc, stalls;
        logic r, prev_stall;
        logic [15:0] held;
        n          = (cnt > 512) ? 512 : cnt;
        a          = b;
        hs         = 0;
        cyc        = 0;
        stalls     = 0;
        prev_stall = 1'b0;
        held       = '0;
        start_xfer(1'b1, b, cnt);
        while (hs < n && cyc < 4 * n + 20) begin
            case (stall_mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom);
                default: r = !(hs == 1 && stalls < 2);
            endcase
            bus.m_ready = r;
            bus.s_valid = 1'($urandom);   // must be ignored in READ
            @(negedge clk);
            n_cmp++;
            if ({bus.m_valid, bus.s_ready, bus.busy, bus.mem_load, bus.mem_address, bus.m_data}
                !== {1'b1, 1'b0, 1'b1, 1'b0, 9'(a), exp_ram[a]}) begin
                n_bad++;
                $display("FAIL %s read_cycle %0d: mv/rdy/busy/load=%b%b%b%b addr=%0d data=%h want 1 0 1 0 addr=%0d data=%h",
                         tag, cyc, bus.m_valid, bus.s_ready, bus.busy, bus.mem_load,
                         bus.mem_address, bus.m_data, a, exp_ram[a]);
            end
            if (prev_stall) begin
                n_cmp++;
                if (bus.m_data !== held) begin
                    n_bad++;
                    $display("FAIL %s read_hold: m_data got %h want %h", tag, bus.m_data, held);
                end
            end
            prev_stall = !r;
            held       = bus.m_data;
            if (!r) stalls++;
            if (r) begin
                a = (a + 1) % 512;
                hs++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b0;
        n_cmp++;
        if (hs != n) begin
            n_bad++;
            $display("FAIL %s read_timeout: handshakes got %0d want %0d", tag, hs, n);
        end
        if (stall_mode == 2) begin
            n_cmp++;
            if (stalls != 2) begin
                n_bad++;
                $display("FAIL %s read_stalls: stall cycles got %0d want 2", tag, stalls);
            end
        end
        finish_xfer(tag);
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.mode = 1'b0; bus.base = '0; bus.count = '0;
        bus.s_data = '0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.s_ready, bus.m_valid, bus.mem_load, bus.mem_address} !== 14'b0) begin
            n_bad++;
            $display("FAIL reset_values: busy/done/rdy/mv/load=%b%b%b%b%b addr=%0d want all 0",
                     bus.busy, bus.done, bus.s_ready, bus.m_valid, bus.mem_load, bus.mem_address);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_write_read();
        logic [15:0] w[$];
        w = '{16'hA1, 16'hB2, 16'hC3};
        run_write(5, 3, 0, w, "write_5x3");
        n_cmp++;
        if ({ram[5], ram[6], ram[7], ram[8]} !== {16'hA1, 16'hB2, 16'hC3, exp_ram[8]}) begin
            n_bad++;
            $display("FAIL write_5x3_ram: ram[5..8] got %h %h %h %h want a1 b2 c3 %h",
                     ram[5], ram[6], ram[7], ram[8], exp_ram[8]);
        end
        run_read(5, 3, 2, "read_5x3_stall");
    endtask

    task automatic test_wrap();
        logic [15:0] w[$];
        w = '{16'd1, 16'd2, 16'd3, 16'd4};
        run_write(510, 4, 0, w, "wrap");
        n_cmp++;
        if ({ram[510], ram[511], ram[0], ram[1]} !== {16'd1, 16'd2, 16'd3, 16'd4}) begin
            n_bad++;
            $display("FAIL wrap_ram: ram[510,511,0,1] got %0d %0d %0d %0d want 1 2 3 4",
                     ram[510], ram[511], ram[0], ram[1]);
        end
        run_read(510, 4, 1, "wrap_read");
    endtask

    task automatic test_edge_counts();
        logic [15:0] none[$];
        bus.s_valid = 1'b1;   // a pending word must not be written for count 0
        start_xfer(1'b0, 77, 0);
        bus.s_valid = 1'b1;
        finish_xfer("count0_write");
        bus.s_valid = 1'b0;
        start_xfer(1'b1, 300, 0);
        finish_xfer("count0_read");
        run_write($urandom_range(0, 511), 700, 0, none, "count700_write");
        run_read($urandom_range(0, 511), 1023, 1, "count1023_read");
    endtask

    task automatic test_gaps();
        logic [15:0] none[$];
        run_write(40, 4, 2, none, "gaps_1001");
        run_read(40, 4, 0, "gaps_readback");
    endtask

    task automatic test_reset_midway();
        int b;
        logic [15:0] w;
        logic [15:0] none[$];
        b = 200;
        start_xfer(1'b0, b, 4);
        for (int i = 0; i < 2; i++) begin
            w = 16'($urandom);
            bus.s_valid = 1'b1;
            bus.s_data  = w;
            exp_ram[b + i] = w;
            @(posedge clk); #1;
        end
        bus.s_data = 16'($urandom);
        #1;
        n_cmp++;
        if ({bus.mem_load, bus.busy, bus.s_ready} !== 3'b111) begin
            n_bad++;
            $display("FAIL midreset_before: load/busy/rdy got %b want 111",
                     {bus.mem_load, bus.busy, bus.s_ready});
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.mem_load, bus.busy, bus.s_ready, bus.m_valid, bus.done} !== 5'b0) begin
            n_bad++;
            $display("FAIL midreset_drop: load/busy/rdy/mv/done got %b want 00000",
                     {bus.mem_load, bus.busy, bus.s_ready, bus.m_valid, bus.done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.mem_address} !== 11'b0) begin
            n_bad++;
            $display("FAIL midreset_idle: busy/done got %b%b addr=%0d want 00 addr=0",
                     bus.busy, bus.done, bus.mem_address);
        end
        run_write(b + 10, 5, 1, none, "after_reset_write");
        run_read(b, 15, 1, "after_reset_read");
    endtask

    task automatic test_random();
        logic [15:0] none[$];
        for (int k = 0; k < 12; k++) begin
            int b, c;
            b = $urandom_range(0, 511);
            c = $urandom_range(1, 40);
            if ($urandom_range(0, 1) == 0)
                run_write(b, c, $urandom_range(0, 2), none, "rand_write");
            else
                run_read(b, c, $urandom_range(0, 1), "rand_read");
        end
    endtask

    task automatic test_full_ram();
        int diffs, first;
        diffs = 0;
        first = -1;
        for (int i = 0; i < 512; i++) begin
            if (ram[i] !== exp_ram[i]) begin
                diffs++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (diffs != 0) begin
            n_bad++;
            $display("FAIL full_ram: %0d words differ, first at %0d got %h want %h",
                     diffs, first, ram[first], exp_ram[first]);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) exp_ram[i] = 16'(i * 37 + 5);
        test_reset();
        test_basic_write_read();
        test_wrap();
        test_edge_counts();
        test_gaps();
        test_reset_midway();
        test_random();
        test_full_ram();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
